// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared encodings for the execute front end.
//   - ALU_* : 4-bit ALU opcodes that the ALU decodes.
//   - op_class_e : coarse instruction class produced by the decoder.
//   - fwd_sel_e : operand source select for the forwarding network.
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1001;
   localparam logic [3:0] ALU_SLL  = 4'b1010;
   localparam logic [3:0] ALU_SRL  = 4'b1011;
   localparam logic [3:0] ALU_SRA  = 4'b1100;

   typedef enum logic [2:0] {
      OP_R      = 3'd0,
      OP_I      = 3'd1,
      OP_LUI    = 3'd2,
      OP_AUIPC  = 3'd3,
      OP_LOAD   = 3'd4,
      OP_STORE  = 3'd5,
      OP_BRANCH = 3'd6,
      OP_JUMP   = 3'd7
   } op_class_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//   Combinational translation of op class / funct3 / funct7[5] into the
//   4-bit ALU opcode that is registered into ID/EX.
// Ports
//   op_class    in  3  instruction class (op_class_e encoding)
//   funct3      in  3  funct3 field
//   funct7b5    in  1  instr[30]
//   alu_control out 4  ALU opcode (ALU_* encodings)
// -----------------------------------------------------------------------------
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [2:0] op_class,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] alu_control
);

   op_class_e cls;
   assign cls = op_class_e'(op_class);

   always_comb begin
      alu_control = ALU_ADD;
      case (cls)
         OP_R, OP_I: begin
            case (funct3)
               // Immediate forms have no SUBI: instr[30] is part of the immediate.
               3'b000:  alu_control = (cls == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               // SRAI keeps instr[30] as a shift-type bit, so both forms honour it.
               3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
         OP_BRANCH: begin
            case (funct3[2:1])
               2'b00:   alu_control = ALU_SUB;   // BEQ/BNE
               2'b10:   alu_control = ALU_SLT;   // BLT/BGE
               2'b11:   alu_control = ALU_SLTU;  // BLTU/BGEU
               default: alu_control = ALU_ADD;   // unused encodings
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register plus operand selection feeding the ALU.
//   Decoded fields are captured on the rising edge (ALU opcode is decoded at
//   capture); MEM/WB results are forwarded combinationally into both source
//   operands using the registered source indices.
// Ports
//   clk, rst_n                        clock, async active-low reset
//   stall, flush                      hazard unit: hold / insert bubble
//   id_*                              decoded instruction from ID
//   mem_fwd_en, mem_rd, mem_result    MEM-stage forwarding source
//   wb_fwd_en, wb_rd, wb_result       WB-stage forwarding source
//   alu_a, alu_b, alu_control         ALU operands and opcode
//   ex_valid, ex_reg_write, ex_rd     EX control
//   ex_pc, ex_store_data, ex_funct3   EX side data for branch/memory
// -----------------------------------------------------------------------------
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [XLEN-1:0]       id_rs1_data,
   input  logic [XLEN-1:0]       id_rs2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [2:0]            id_op_class,
   input  logic [2:0]            id_funct3,
   input  logic                  id_funct7b5,
   input  logic                  id_reg_write,
   input  logic                  mem_fwd_en,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_result,
   input  logic                  wb_fwd_en,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_result,
   output logic [XLEN-1:0]       alu_a,
   output logic [XLEN-1:0]       alu_b,
   output logic [3:0]            alu_control,
   output logic                  ex_valid,
   output logic                  ex_reg_write,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_store_data,
   output logic [2:0]            ex_funct3
);

   logic [3:0] dec_control;

   alu_decoder u_alu_decoder (
      .op_class    (id_op_class),
      .funct3      (id_funct3),
      .funct7b5    (id_funct7b5),
      .alu_control (dec_control)
   );

   // ---------------- ID/EX register boundary ----------------
   logic                  valid_p1;
   logic                  reg_write_p1;
   logic [REG_ADDR_W-1:0] rd_p1;
   logic [REG_ADDR_W-1:0] rs1_p1;
   logic [REG_ADDR_W-1:0] rs2_p1;
   logic [XLEN-1:0]       pc_p1;
   logic [XLEN-1:0]       rs1_data_p1;
   logic [XLEN-1:0]       rs2_data_p1;
   logic [XLEN-1:0]       imm_p1;
   op_class_e             op_class_p1;
   logic [2:0]            funct3_p1;
   logic [3:0]            control_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_p1     <= 1'b0;
         reg_write_p1 <= 1'b0;
         rd_p1        <= '0;
         rs1_p1       <= '0;
         rs2_p1       <= '0;
         pc_p1        <= '0;
         rs1_data_p1  <= '0;
         rs2_data_p1  <= '0;
         imm_p1       <= '0;
         op_class_p1  <= OP_R;
         funct3_p1    <= '0;
         control_p1   <= ALU_ADD;
      end else if (flush) begin
         // Bubble: source indices cleared too so a dead slot never pulls in
         // forwarded values.
         valid_p1     <= 1'b0;
         reg_write_p1 <= 1'b0;
         rd_p1        <= '0;
         rs1_p1       <= '0;
         rs2_p1       <= '0;
         control_p1   <= ALU_ADD;
      end else if (!stall) begin
         valid_p1     <= id_valid;
         reg_write_p1 <= id_reg_write & id_valid;
         rd_p1        <= id_rd;
         rs1_p1       <= id_rs1;
         rs2_p1       <= id_rs2;
         pc_p1        <= id_pc;
         rs1_data_p1  <= id_rs1_data;
         rs2_data_p1  <= id_rs2_data;
         imm_p1       <= id_imm;
         op_class_p1  <= op_class_e'(id_op_class);
         funct3_p1    <= id_funct3;
         control_p1   <= dec_control;
      end
   end

   // Younger producer (MEM) wins over older (WB); x0 is never a forward target.
   function automatic fwd_sel_e fwd_select(
      input logic [REG_ADDR_W-1:0] rs,
      input logic                  m_en,
      input logic [REG_ADDR_W-1:0] m_rd,
      input logic                  w_en,
      input logic [REG_ADDR_W-1:0] w_rd
   );
      fwd_sel_e sel;
      sel = FWD_REG;
      if (rs != '0) begin
         if (m_en && m_rd == rs)
            sel = FWD_MEM;
         else if (w_en && w_rd == rs)
            sel = FWD_WB;
      end
      return sel;
   endfunction

   fwd_sel_e        sel_rs1;
   fwd_sel_e        sel_rs2;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   assign sel_rs1 = fwd_select(rs1_p1, mem_fwd_en, mem_rd, wb_fwd_en, wb_rd);
   assign sel_rs2 = fwd_select(rs2_p1, mem_fwd_en, mem_rd, wb_fwd_en, wb_rd);

   always_comb begin
      fwd_rs1 = rs1_data_p1;
      case (sel_rs1)
         FWD_MEM: fwd_rs1 = mem_result;
         FWD_WB:  fwd_rs1 = wb_result;
         default: fwd_rs1 = rs1_data_p1;
      endcase
   end

   always_comb begin
      fwd_rs2 = rs2_data_p1;
      case (sel_rs2)
         FWD_MEM: fwd_rs2 = mem_result;
         FWD_WB:  fwd_rs2 = wb_result;
         default: fwd_rs2 = rs2_data_p1;
      endcase
   end

   always_comb begin
      alu_a = fwd_rs1;
      case (op_class_p1)
         OP_LUI:           alu_a = '0;
         OP_AUIPC, OP_JUMP: alu_a = pc_p1;
         default:          alu_a = fwd_rs1;
      endcase
   end

   always_comb begin
      alu_b = imm_p1;
      case (op_class_p1)
         OP_R, OP_BRANCH: alu_b = fwd_rs2;
         default:         alu_b = imm_p1;
      endcase
   end

   assign alu_control   = control_p1;
   assign ex_valid      = valid_p1;
   assign ex_reg_write  = reg_write_p1 & valid_p1;
   assign ex_rd         = rd_p1;
   assign ex_pc         = pc_p1;
   assign ex_store_data = fwd_rs2;
   assign ex_funct3     = funct3_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed table-driven bench for id_ex_stage plus hand-written stall,
//   flush and asynchronous-reset sequences.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
   import riscv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        stall, flush;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_op_class, id_funct3;
   logic        id_funct7b5, id_reg_write;
   logic        mem_fwd_en;
   logic [4:0]  mem_rd;
   logic [31:0] mem_result;
   logic        wb_fwd_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_control;
   logic        ex_valid, ex_reg_write;
   logic [4:0]  ex_rd;
   logic [31:0] ex_pc, ex_store_data;
   logic [2:0]  ex_funct3;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_op_class(id_op_class),
      .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
      .id_reg_write(id_reg_write), .mem_fwd_en(mem_fwd_en), .mem_rd(mem_rd),
      .mem_result(mem_result), .wb_fwd_en(wb_fwd_en), .wb_rd(wb_rd),
      .wb_result(wb_result), .alu_a(alu_a), .alu_b(alu_b),
      .alu_control(alu_control), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_pc(ex_pc),
      .ex_store_data(ex_store_data), .ex_funct3(ex_funct3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        valid;
      logic        rw;
      logic [31:0] pc;
      logic [2:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic        men;
      logic [4:0]  mrd;
      logic [31:0] mres;
      logic        wen;
      logic [4:0]  wrd;
      logic [31:0] wres;
      logic [3:0]  e_ctrl;
      logic [31:0] e_a, e_b, e_sd;
      logic        e_valid, e_rw;
   } vec_t;

   function automatic vec_t mk(input logic [2:0] opc, input logic [2:0] f3, input logic f7,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                               input logic [3:0] ec, input logic [31:0] ea,
                               input logic [31:0] eb, input logic [31:0] esd);
      vec_t v;
      v.valid = 1'b1; v.rw = 1'b1; v.pc = 32'h40; v.rd = 5'd7;
      v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2;
      v.d1 = d1; v.d2 = d2; v.imm = imm;
      v.men = 1'b0; v.mrd = 5'd0; v.mres = 32'h0;
      v.wen = 1'b0; v.wrd = 5'd0; v.wres = 32'h0;
      v.e_ctrl = ec; v.e_a = ea; v.e_b = eb; v.e_sd = esd;
      v.e_valid = 1'b1; v.e_rw = 1'b1;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      id_valid = v.valid; id_reg_write = v.rw; id_pc = v.pc;
      id_op_class = v.opc; id_funct3 = v.f3; id_funct7b5 = v.f7;
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
      id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm;
      mem_fwd_en = v.men; mem_rd = v.mrd; mem_result = v.mres;
      wb_fwd_en = v.wen; wb_rd = v.wrd; wb_result = v.wres;
   endtask

   vec_t tv[$];
   vec_t v;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      stall = 0; flush = 0; rst_n = 0;
      v = mk(OP_R, 3'd0, 1'b0, 5'd0, 5'd0, 0, 0, 0, ALU_ADD, 0, 0, 0);
      v.valid = 0; v.rw = 0; v.rd = 0; v.pc = 0;
      drive(v);

      // ---------------- vector table ----------------
      tv.push_back(mk(OP_R, 3'b000, 1'b1, 5'd5, 5'd3, 10, 4, 0, ALU_SUB, 10, 4, 4));
      v = mk(OP_R, 3'b000, 1'b0, 5'd5, 5'd3, 10, 4, 0, ALU_ADD, 99, 4, 4);
      v.men = 1; v.mrd = 5; v.mres = 99; v.wen = 1; v.wrd = 5; v.wres = 77;
      tv.push_back(v);
      v.men = 0; v.e_a = 77;
      tv.push_back(v);
      v = mk(OP_R, 3'b000, 1'b0, 5'd0, 5'd3, 0, 4, 0, ALU_ADD, 0, 4, 4);
      v.men = 1; v.mrd = 0; v.mres = 55; v.wen = 1; v.wrd = 0; v.wres = 66;
      tv.push_back(v);
      tv.push_back(mk(OP_LUI, 3'd0, 1'b0, 5'd0, 5'd0, 0, 0, 32'h12345000, ALU_ADD, 0, 32'h12345000, 0));
      v = mk(OP_AUIPC, 3'd0, 1'b0, 5'd0, 5'd0, 0, 0, 32'h2000, ALU_ADD, 32'h100, 32'h2000, 0);
      v.pc = 32'h100;
      tv.push_back(v);
      tv.push_back(mk(OP_BRANCH, 3'b110, 1'b0, 5'd1, 5'd2, 3, 5, 32'h10, ALU_SLTU, 3, 5, 5));
      tv.push_back(mk(OP_I, 3'b000, 1'b1, 5'd1, 5'd0, 20, 0, 5, ALU_ADD, 20, 5, 0));
      tv.push_back(mk(OP_R, 3'b101, 1'b1, 5'd1, 5'd2, 8, 2, 0, ALU_SRA, 8, 2, 2));
      tv.push_back(mk(OP_I, 3'b101, 1'b1, 5'd1, 5'd0, 8, 0, 3, ALU_SRA, 8, 3, 0));
      tv.push_back(mk(OP_I, 3'b101, 1'b0, 5'd1, 5'd0, 8, 0, 3, ALU_SRL, 8, 3, 0));
      tv.push_back(mk(OP_R, 3'b111, 1'b0, 5'd1, 5'd2, 8, 2, 0, ALU_AND, 8, 2, 2));
      tv.push_back(mk(OP_R, 3'b110, 1'b0, 5'd1, 5'd2, 8, 2, 0, ALU_OR, 8, 2, 2));
      tv.push_back(mk(OP_R, 3'b100, 1'b0, 5'd1, 5'd2, 8, 2, 0, ALU_XOR, 8, 2, 2));
      tv.push_back(mk(OP_R, 3'b001, 1'b0, 5'd1, 5'd2, 8, 2, 0, ALU_SLL, 8, 2, 2));
      tv.push_back(mk(OP_R, 3'b010, 1'b0, 5'd1, 5'd2, 8, 2, 0, ALU_SLT, 8, 2, 2));
      tv.push_back(mk(OP_R, 3'b011, 1'b0, 5'd1, 5'd2, 8, 2, 0, ALU_SLTU, 8, 2, 2));
      tv.push_back(mk(OP_BRANCH, 3'b000, 1'b0, 5'd1, 5'd2, 8, 2, 12, ALU_SUB, 8, 2, 2));
      tv.push_back(mk(OP_BRANCH, 3'b100, 1'b0, 5'd1, 5'd2, 8, 2, 12, ALU_SLT, 8, 2, 2));
      tv.push_back(mk(OP_BRANCH, 3'b010, 1'b0, 5'd1, 5'd2, 8, 2, 12, ALU_ADD, 8, 2, 2));
      v = mk(OP_STORE, 3'b010, 1'b0, 5'd1, 5'd4, 32'h1000, 32'h55, 8, ALU_ADD, 32'h1000, 8, 32'hAA);
      v.wen = 1; v.wrd = 4; v.wres = 32'hAA; v.rw = 0; v.e_rw = 0;
      tv.push_back(v);
      v = mk(OP_JUMP, 3'b000, 1'b0, 5'd0, 5'd0, 0, 0, 4, ALU_ADD, 32'h200, 4, 0);
      v.pc = 32'h200;
      tv.push_back(v);
      v = mk(OP_LOAD, 3'b010, 1'b0, 5'd6, 5'd0, 32'h9, 0, 4, ALU_ADD, 32'h300, 4, 0);
      v.men = 1; v.mrd = 6; v.mres = 32'h300; v.wen = 1; v.wrd = 6; v.wres = 32'h400;
      tv.push_back(v);
      v.valid = 0; v.e_valid = 0; v.e_rw = 0;
      tv.push_back(v);

      // ---------------- reset state ----------------
      #12;
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
      chk("rst_ctrl", {28'd0, alu_control}, {28'd0, ALU_ADD});
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      @(negedge clk);
      rst_n = 1;

      // ---------------- table loop ----------------
      foreach (tv[i]) begin
         drive(tv[i]);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ctrl", i), {28'd0, alu_control}, {28'd0, tv[i].e_ctrl});
         chk($sformatf("v%0d_alu_a", i), alu_a, tv[i].e_a);
         chk($sformatf("v%0d_alu_b", i), alu_b, tv[i].e_b);
         chk($sformatf("v%0d_store", i), ex_store_data, tv[i].e_sd);
         chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, tv[i].e_valid});
         chk($sformatf("v%0d_regw", i), {31'd0, ex_reg_write}, {31'd0, tv[i].e_rw});
         chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, tv[i].rd});
         chk($sformatf("v%0d_pc", i), ex_pc, tv[i].pc);
         chk($sformatf("v%0d_f3", i), {29'd0, ex_funct3}, {29'd0, tv[i].f3});
      end

      // ---------------- stall with late WB forward, then flush+stall ----------------
      v = mk(OP_R, 3'b000, 1'b0, 5'd1, 5'd2, 1, 2, 0, ALU_ADD, 1, 2, 2);
      v.rd = 9;
      drive(v);
      @(posedge clk);
      #1;
      stall = 1;
      drive(tv[0]);  // different instruction waiting in ID must not enter
      @(posedge clk);
      #1;
      chk("stall1_a", alu_a, 32'd1);
      chk("stall1_b", alu_b, 32'd2);
      chk("stall1_rd", {27'd0, ex_rd}, 32'd9);
      chk("stall1_ctrl", {28'd0, alu_control}, {28'd0, ALU_ADD});
      wb_fwd_en = 1; wb_rd = 5'd2; wb_result = 32'h77;
      #1;
      chk("stall2_b_comb", alu_b, 32'h77);
      @(posedge clk);
      #1;
      chk("stall2_b", alu_b, 32'h77);
      chk("stall2_store", ex_store_data, 32'h77);
      chk("stall2_rd", {27'd0, ex_rd}, 32'd9);
      chk("stall2_valid", {31'd0, ex_valid}, 32'd1);
      @(posedge clk);
      #1;
      chk("stall3_ctrl", {28'd0, alu_control}, {28'd0, ALU_ADD});
      chk("stall3_a", alu_a, 32'd1);
      flush = 1;
      @(posedge clk);
      #1;
      chk("flush_valid", {31'd0, ex_valid}, 32'd0);
      chk("flush_regw", {31'd0, ex_reg_write}, 32'd0);
      chk("flush_rd", {27'd0, ex_rd}, 32'd0);
      chk("flush_ctrl", {28'd0, alu_control}, {28'd0, ALU_ADD});
      flush = 0; stall = 0;

      // ---------------- asynchronous reset between edges ----------------
      drive(tv[0]);
      @(posedge clk);
      #1;
      chk("pre_rst_ctrl", {28'd0, alu_control}, {28'd0, ALU_SUB});
      chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      chk("arst_valid", {31'd0, ex_valid}, 32'd0);
      chk("arst_regw", {31'd0, ex_reg_write}, 32'd0);
      chk("arst_ctrl", {28'd0, alu_control}, {28'd0, ALU_ADD});
      chk("arst_alu_a", alu_a, 32'd0);
      @(posedge clk);
      #1;
      chk("arst_hold_valid", {31'd0, ex_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
